zero_cross_meter: RTL and testbench



---
 rtl/zero_cross_meter.sv | 136 +++++++++++++
 tb/tb_zero_cross_meter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/zero_cross_meter.sv
// zero_cross_meter: per-channel tone self-test measuring the period and peak between rising zero crossings
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    measurement enable; low returns the meter to IDLE
//   smpl_vld, smpl        sample strobe and signed 16-bit sample
//   min_cnt, max_cnt      legal period window in samples
//   min_ampl, max_ampl    legal signed peak window
//   clr_errs              clears both error counters
//   period_cnt, peak      last measured period and signed peak
//   meas_vld              one-cycle pulse per new measurement
//   freq_err, ampl_err    out-of-window flags, pulsed with meas_vld
//   freq_err_cnt, ampl_err_cnt  saturating error counts
module zero_cross_meter #(
  parameter int SMOOTH_LOG2 = 0,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                smpl_vld,
  input  logic signed [15:0]  smpl,
  input  logic [CNT_W-1:0]    min_cnt,
  input  logic [CNT_W-1:0]    max_cnt,
  input  logic signed [15:0]  min_ampl,
  input  logic signed [15:0]  max_ampl,
  input  logic                clr_errs,
  output logic [CNT_W-1:0]    period_cnt,
  output logic signed [15:0]  peak,
  output logic                meas_vld,
  output logic                freq_err,
  output logic                ampl_err,
  output logic [7:0]          freq_err_cnt,
  output logic [7:0]          ampl_err_cnt
);
  localparam int N = 1 << SMOOTH_LOG2;
  localparam int SW = 16 + SMOOTH_LOG2;
  typedef enum logic [1:0] {IDLE, FILL, SYNC, MEAS} state_t;
  state_t r_state, w_next;
  logic signed [15:0] r_win [N];
  logic signed [SW-1:0] r_sum, w_sum;
  logic signed [15:0] r_sm, r_sm_prev, r_pk, r_peak;
  logic r_sm_upd, r_meas_vld, r_ferr, r_aerr;
  logic [3:0] r_fill;
  logic [CNT_W-1:0] r_cnt, r_period, w_period;
  logic [7:0] r_fcnt, r_acnt;
  logic w_xing, w_sat, w_meas, w_ferr, w_aerr;
  // running sum: add the new sample, drop the one leaving the window (modular, so no overflow issue)
  assign w_sum = r_sum + SW'(smpl) - SW'(r_win[N-1]);
  assign w_xing = r_sm_upd & r_sm_prev[15] & ~r_sm[15];
  assign w_sat = &r_cnt;
  assign w_period = w_sat ? r_cnt : r_cnt + CNT_W'(1);
  assign w_meas = en & w_xing & (r_state == MEAS);
  // a saturated counter means the true period is unknown, so it always fails
  assign w_ferr = (w_period < min_cnt) | (w_period > max_cnt) | w_sat;
  assign w_aerr = (r_pk < min_ampl) | (r_pk > max_ampl);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) r_win[k] <= '0;
      r_sum <= '0;
      r_sm <= '0;
      r_sm_prev <= '0;
      r_sm_upd <= 1'b0;
    end else if (!en) begin
      for (int k = 0; k < N; k++) r_win[k] <= '0;
      r_sum <= '0;
      r_sm <= '0;
      r_sm_prev <= '0;
      r_sm_upd <= 1'b0;
    end else begin
      r_sm_upd <= smpl_vld;
      if (r_sm_upd) r_sm_prev <= r_sm;
      if (smpl_vld) begin
        r_win[0] <= smpl;
        for (int k = 1; k < N; k++) r_win[k] <= r_win[k-1];
        r_sum <= w_sum;
        r_sm <= 16'(w_sum >>> SMOOTH_LOG2);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    w_next = !en ? IDLE :
             (r_state == IDLE) ? FILL :
             (r_state == FILL && r_sm_upd && r_fill == 4'(N-1)) ? SYNC :
             (r_state == SYNC && w_xing) ? MEAS : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fill <= '0;
      r_cnt <= '0;
      r_pk <= '0;
    end else begin
      r_state <= w_next;
      r_fill <= (!en || r_state != FILL) ? '0 : r_sm_upd ? r_fill + 4'd1 : r_fill;
      if (!en) begin
        r_cnt <= '0;
        r_pk <= '0;
      end else if (w_xing && (r_state == SYNC || r_state == MEAS)) begin
        r_cnt <= '0;
        r_pk <= r_sm;
      end else if (r_sm_upd && r_state == MEAS) begin
        r_cnt <= w_period;
        r_pk <= (r_sm > r_pk) ? r_sm : r_pk;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_vld <= 1'b0;
      r_ferr <= 1'b0;
      r_aerr <= 1'b0;
      r_period <= '0;
      r_peak <= '0;
      r_fcnt <= '0;
      r_acnt <= '0;
    end else begin
      r_meas_vld <= w_meas;
      r_ferr <= w_meas & w_ferr;
      r_aerr <= w_meas & w_aerr;
      if (w_meas) begin
        r_period <= w_period;
        r_peak <= r_pk;
      end
      // a clear coinciding with an error pulse leaves that error counted
      r_fcnt <= clr_errs ? 8'(r_ferr) : (r_ferr && r_fcnt != 8'hff) ? r_fcnt + 8'd1 : r_fcnt;
      r_acnt <= clr_errs ? 8'(r_aerr) : (r_aerr && r_acnt != 8'hff) ? r_acnt + 8'd1 : r_acnt;
    end
  end
  assign period_cnt = r_period;
  assign peak = r_peak;
  assign meas_vld = r_meas_vld;
  assign freq_err = r_ferr;
  assign ampl_err = r_aerr;
  assign freq_err_cnt = r_fcnt;
  assign ampl_err_cnt = r_acnt;
endmodule

// File: tb/tb_zero_cross_meter.sv
// tb_zero_cross_meter: directed bench for two meter instances (no smoothing and 2-sample smoothing)
module tb_zero_cross_meter;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, smpl_vld = 1'b0, clr_errs = 1'b0;
  logic signed [15:0] smpl = '0, min_ampl, max_ampl;
  logic [7:0] min_cnt, max_cnt;
  logic [7:0] period_cnt [2];
  logic signed [15:0] peak [2];
  logic meas_vld [2], freq_err [2], ampl_err [2];
  logic [7:0] fcnt [2], acnt [2];
  int errors = 0, checks = 0;
  int win [2][8];
  int upd [2], prev [2], syn [2], len [2], pk [2];
  int p_mv [2], p_fe [2], p_ae [2], p_per [2], p_pk [2];
  int e_mv [2], e_fe [2], e_ae [2], e_per [2], e_pk [2], e_fc [2], e_ac [2];
  int n_mv [2];
  zero_cross_meter #(.SMOOTH_LOG2(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .smpl_vld(smpl_vld), .smpl(smpl),
    .min_cnt(min_cnt), .max_cnt(max_cnt), .min_ampl(min_ampl), .max_ampl(max_ampl),
    .clr_errs(clr_errs), .period_cnt(period_cnt[0]), .peak(peak[0]), .meas_vld(meas_vld[0]),
    .freq_err(freq_err[0]), .ampl_err(ampl_err[0]), .freq_err_cnt(fcnt[0]), .ampl_err_cnt(acnt[0])
  );
  zero_cross_meter #(.SMOOTH_LOG2(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .smpl_vld(smpl_vld), .smpl(smpl),
    .min_cnt(min_cnt), .max_cnt(max_cnt), .min_ampl(min_ampl), .max_ampl(max_ampl),
    .clr_errs(clr_errs), .period_cnt(period_cnt[1]), .peak(peak[1]), .meas_vld(meas_vld[1]),
    .freq_err(freq_err[1]), .ampl_err(ampl_err[1]), .freq_err_cnt(fcnt[1]), .ampl_err_cnt(acnt[1])
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("meas_vld[%0d]", i), int'(meas_vld[i]), e_mv[i]);
      chk($sformatf("freq_err[%0d]", i), int'(freq_err[i]), e_fe[i]);
      chk($sformatf("ampl_err[%0d]", i), int'(ampl_err[i]), e_ae[i]);
      chk($sformatf("period_cnt[%0d]", i), int'(period_cnt[i]), e_per[i]);
      chk($sformatf("peak[%0d]", i), int'(peak[i]), e_pk[i]);
      chk($sformatf("freq_err_cnt[%0d]", i), int'(fcnt[i]), e_fc[i]);
      chk($sformatf("ampl_err_cnt[%0d]", i), int'(acnt[i]), e_ac[i]);
      n_mv[i] += int'(meas_vld[i]);
    end
  end
  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) win[i][k] = 0;
      upd[i] = 0; prev[i] = 0; syn[i] = 0; len[i] = 0; pk[i] = 0;
    end
  endtask
  // sample-level view: moving average, skip the fill updates, the first rising crossing
  // only synchronises, every later one closes a period of len samples
  task automatic model_step(int v);
    for (int i = 0; i < 2; i++) begin
      int n, sum, sm;
      bit x;
      n = 1 << i;
      sum = 0;
      for (int k = 7; k > 0; k--) win[i][k] = win[i][k-1];
      win[i][0] = v;
      for (int k = 0; k < n; k++) sum += win[i][k];
      sm = sum >>> i;
      p_mv[i] = 0; p_fe[i] = 0; p_ae[i] = 0;
      upd[i]++;
      x = prev[i] < 0 && sm >= 0;
      prev[i] = sm;
      if (upd[i] > n) begin
        if (x) begin
          if (syn[i] != 0) begin
            p_per[i] = len[i] > 255 ? 255 : len[i];
            p_mv[i] = 1;
            p_pk[i] = pk[i];
            p_fe[i] = int'(p_per[i] < int'(min_cnt) || p_per[i] > int'(max_cnt) || len[i] > 255);
            p_ae[i] = int'(pk[i] < int'(min_ampl) || pk[i] > int'(max_ampl));
          end
          syn[i] = 1; len[i] = 1; pk[i] = sm;
        end else if (syn[i] != 0) begin
          len[i]++;
          if (sm > pk[i]) pk[i] = sm;
        end
      end
    end
  endtask
  task automatic send(int v, bit clr = 1'b0);
    @(negedge clk);
    smpl = 16'(v);
    smpl_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin p_mv[i] = 0; p_fe[i] = 0; p_ae[i] = 0; end
    if (en) model_step(v);
    @(negedge clk);
    smpl_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_mv[i] = p_mv[i]; e_fe[i] = p_fe[i]; e_ae[i] = p_ae[i];
      if (p_mv[i] != 0) begin e_per[i] = p_per[i]; e_pk[i] = p_pk[i]; end
    end
    @(negedge clk);
    clr_errs = clr;
    for (int i = 0; i < 2; i++) begin
      e_mv[i] = 0; e_fe[i] = 0; e_ae[i] = 0;
      e_fc[i] = clr ? p_fe[i] : (p_fe[i] != 0 && e_fc[i] < 255) ? e_fc[i] + 1 : e_fc[i];
      e_ac[i] = clr ? p_ae[i] : (p_ae[i] != 0 && e_ac[i] < 255) ? e_ac[i] + 1 : e_ac[i];
    end
    @(negedge clk);
    clr_errs = 1'b0;
  endtask
  task automatic clr();
    @(negedge clk);
    clr_errs = 1'b1;
    for (int i = 0; i < 2; i++) begin e_fc[i] = 0; e_ac[i] = 0; end
    @(negedge clk);
    clr_errs = 1'b0;
  endtask
  task automatic set_en(bit b);
    @(negedge clk);
    en = b;
    if (!b) model_clear();
    repeat (2) @(negedge clk);
  endtask
  function automatic int sine(int k, int p, int a);
    return int'(a * $sin(2.0 * 3.14159265358979 * k / p));
  endfunction
  task automatic sine_run(int p, int a, int periods);
    for (int k = 0; k <= p * periods; k++) send(sine(k % p, p, a));
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst period_cnt[%0d]", i), int'(period_cnt[i]), 0);
      chk($sformatf("rst peak[%0d]", i), int'(peak[i]), 0);
      chk($sformatf("rst meas_vld[%0d]", i), int'(meas_vld[i]), 0);
      chk($sformatf("rst freq_err_cnt[%0d]", i), int'(fcnt[i]), 0);
      chk($sformatf("rst ampl_err_cnt[%0d]", i), int'(acnt[i]), 0);
      e_mv[i] = 0; e_fe[i] = 0; e_ae[i] = 0; e_per[i] = 0; e_pk[i] = 0; e_fc[i] = 0; e_ac[i] = 0;
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int b0, b1;
    min_cnt = 8'd6; max_cnt = 8'd10; min_ampl = 16'sd3000; max_ampl = 16'sd5000;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_en(1'b1);
    b0 = n_mv[0];
    sine_run(8, 4000, 6);
    chk("sine8 meas count", n_mv[0] - b0, 5);
    chk("sine8 period", int'(period_cnt[0]), 8);
    chk("sine8 peak", int'(peak[0]), 4000);
    chk("sine8 freq_err_cnt", int'(fcnt[0]), 0);
    chk("sine8 ampl_err_cnt", int'(acnt[0]), 0);
    set_en(1'b0); set_en(1'b1); clr();
    b0 = n_mv[0];
    sine_run(20, 4000, 6);
    chk("sine20 meas count", n_mv[0] - b0, 5);
    chk("sine20 period", int'(period_cnt[0]), 20);
    chk("sine20 freq_err_cnt", int'(fcnt[0]), 5);
    chk("sine20 ampl_err_cnt", int'(acnt[0]), 0);
    set_en(1'b0); set_en(1'b1); clr();
    sine_run(8, 6000, 6);
    chk("loud ampl_err_cnt", int'(acnt[0]), 5);
    chk("loud peak", int'(peak[0]), 6000);
    chk("loud freq_err_cnt", int'(fcnt[0]), 0);
    set_en(1'b0); set_en(1'b1);
    b1 = n_mv[1];
    for (int k = 0; k < 50; k++) send(k % 2 == 1 ? 1000 : 3000);
    chk("dc smooth meas count", n_mv[1] - b1, 0);
    for (int k = 0; k <= 32; k++) send((k % 8) < 4 ? 4000 : -4000);
    chk("square smooth period", int'(period_cnt[1]), 8);
    chk("square smooth peak", int'(peak[1]), 4000);
    clr();
    for (int k = 0; k < 300; k++) send(-1000);
    send(4000);
    chk("long period0", int'(period_cnt[0]), 255);
    chk("long period1", int'(period_cnt[1]), 255);
    chk("long freq_err_cnt0", int'(fcnt[0]), 1);
    chk("long freq_err_cnt1", int'(fcnt[1]), 1);
    sine_run(8, 4000, 2);
    chk("pre-drop period", int'(period_cnt[0]), 8);
    send(2828); send(4000);
    set_en(1'b0);
    b0 = n_mv[0];
    set_en(1'b1);
    sine_run(8, 4000, 1);
    chk("resync no meas", n_mv[0] - b0, 0);
    chk("held period", int'(period_cnt[0]), 8);
    sine_run(8, 4000, 1);
    chk("resync one meas", n_mv[0] - b0, 1);
    min_cnt = 8'd10; max_cnt = 8'd9;
    clr();
    for (int k = 0; k < 300; k++) begin send(100); send(-100); end
    chk("sat freq_err_cnt", int'(fcnt[0]), 255);
    chk("sat ampl_err_cnt", int'(acnt[0]), 255);
    send(100, 1'b1);
    chk("clr+err freq_err_cnt", int'(fcnt[0]), 1);
    chk("clr+err ampl_err_cnt", int'(acnt[0]), 1);
    do_reset();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
